// File: rtl/code_lock_ctrl.sv
// Code lock controller: stores a key, checks entries against an external
// equality comparator, and enforces a timed lockout after repeated failures.
module code_lock_ctrl #(
  parameter int BITS           = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 100000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] sw,
  input  logic            btn_set,
  input  logic            btn_check,
  input  logic            eq,
  output logic [BITS-1:0] key_out,
  output logic [BITS-1:0] entry_out,
  output logic            unlocked,
  output logic            alarm,
  output logic [2:0]      tries_left
);

  localparam int CNT_W = $clog2(LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       TRIES_INIT = 3'(MAX_TRIES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_COMPARE  = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [BITS-1:0]  key_reg, key_next;
  logic [BITS-1:0]  entry_reg, entry_next;
  logic [2:0]       tries_reg, tries_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             set_q_reg, check_q_reg;
  logic             set_press, check_press;

  // Button history resets high so a button held through reset is not a press.
  assign set_press   = btn_set & ~set_q_reg;
  assign check_press = btn_check & ~check_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_UNLOCKED;
      key_reg     <= '0;
      entry_reg   <= '0;
      tries_reg   <= TRIES_INIT;
      cnt_reg     <= '0;
      set_q_reg   <= 1'b1;
      check_q_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      key_reg     <= key_next;
      entry_reg   <= entry_next;
      tries_reg   <= tries_next;
      cnt_reg     <= cnt_next;
      set_q_reg   <= btn_set;
      check_q_reg <= btn_check;
    end
  end

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    entry_next = entry_reg;
    tries_next = tries_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_UNLOCKED: begin
        if (set_press) begin
          key_next   = sw;
          tries_next = TRIES_INIT;
          state_next = ST_LOCKED;
        end else if (check_press) begin
          state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (check_press) begin
          entry_next = sw;
          state_next = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (eq) begin
          tries_next = TRIES_INIT;
          state_next = ST_UNLOCKED;
        end else if (tries_reg > 3'd1) begin
          tries_next = tries_reg - 3'd1;
          state_next = ST_LOCKED;
        end else begin
          tries_next = 3'd0;
          cnt_next   = CNT_LOAD;
          state_next = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        // Counter runs LOCKOUT_CYCLES-1 down to 0, one state cycle per count.
        if (cnt_reg == '0) begin
          tries_next = TRIES_INIT;
          state_next = ST_LOCKED;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: state_next = ST_UNLOCKED;
    endcase
  end

  assign key_out    = key_reg;
  assign entry_out  = entry_reg;
  assign tries_left = tries_reg;
  assign unlocked   = (state_reg == ST_UNLOCKED);
  assign alarm      = (state_reg == ST_LOCKOUT);

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed testbench for code_lock_ctrl with an external equality comparator.
module tb_code_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_set;
  logic       btn_check;
  logic       eq;
  logic [3:0] key_out;
  logic [3:0] entry_out;
  logic       unlocked;
  logic       alarm;
  logic [2:0] tries_left;

  int checks   = 0;
  int failures = 0;

  code_lock_ctrl #(
    .BITS(4),
    .MAX_TRIES(3),
    .LOCKOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .btn_set(btn_set),
    .btn_check(btn_check),
    .eq(eq),
    .key_out(key_out),
    .entry_out(entry_out),
    .unlocked(unlocked),
    .alarm(alarm),
    .tries_left(tries_left)
  );

  // Board-level comparator fed by the lock's own operands.
  assign eq = (key_out == entry_out);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One check press with the given entry, then release through the compare.
  task automatic attempt(input logic [3:0] val);
    sw = val;
    btn_check = 1'b1;
    tick();
    btn_check = 1'b0;
    tick();
  endtask

  int n;

  initial begin
    rst = 1'b1; sw = 4'h0; btn_set = 1'b0; btn_check = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_unlocked", 32'(unlocked), 32'd1);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_key", 32'(key_out), 32'h0);
    chk("rst_entry", 32'(entry_out), 32'h0);
    chk("rst_tries", 32'(tries_left), 32'd3);
    tick();

    // Store key A
    sw = 4'hA; btn_set = 1'b1;
    tick();
    chk("set_key", 32'(key_out), 32'hA);
    chk("set_locked", 32'(unlocked), 32'd0);
    chk("set_tries", 32'(tries_left), 32'd3);
    btn_set = 1'b0;
    tick();

    // Correct entry: entry after 1 edge, unlocked after 2
    sw = 4'hA; btn_check = 1'b1;
    tick();
    chk("ok_entry_k", 32'(entry_out), 32'hA);
    chk("ok_unlocked_k", 32'(unlocked), 32'd0);
    btn_check = 1'b0;
    tick();
    chk("ok_unlocked_k1", 32'(unlocked), 32'd1);
    chk("ok_tries", 32'(tries_left), 32'd3);

    // Relock with check press, key unchanged
    sw = 4'h7;
    btn_check = 1'b1;
    tick();
    chk("relock_locked", 32'(unlocked), 32'd0);
    chk("relock_key", 32'(key_out), 32'hA);
    btn_check = 1'b0;
    tick();

    // Three failures -> lockout
    attempt(4'h5);
    chk("fail1_tries", 32'(tries_left), 32'd2);
    chk("fail1_locked", 32'(unlocked), 32'd0);
    attempt(4'h5);
    chk("fail2_tries", 32'(tries_left), 32'd1);
    attempt(4'h5);
    chk("fail3_tries", 32'(tries_left), 32'd0);
    chk("fail3_alarm", 32'(alarm), 32'd1);
    n = 1;
    for (int i = 0; i < 50 && alarm; i++) begin
      if (i == 2) begin sw = 4'h9; btn_check = 1'b1; end
      if (i == 3) btn_check = 1'b0;
      tick();
      if (alarm) n++;
    end
    chk("alarm_cycles", 32'(n), 32'd8);
    chk("lockout_done_alarm", 32'(alarm), 32'd0);
    chk("lockout_done_locked", 32'(unlocked), 32'd0);
    chk("lockout_done_tries", 32'(tries_left), 32'd3);
    chk("lockout_entry_held", 32'(entry_out), 32'h5);
    tick();

    // Two failures then correct entry
    attempt(4'h5);
    chk("retry1_tries", 32'(tries_left), 32'd2);
    attempt(4'h6);
    chk("retry2_tries", 32'(tries_left), 32'd1);
    attempt(4'hA);
    chk("retry_ok_unlocked", 32'(unlocked), 32'd1);
    chk("retry_ok_tries", 32'(tries_left), 32'd3);

    // Set and check in the same cycle: set wins
    sw = 4'h3; btn_set = 1'b1; btn_check = 1'b1;
    tick();
    chk("both_key", 32'(key_out), 32'h3);
    chk("both_locked", 32'(unlocked), 32'd0);
    btn_set = 1'b0;
    tick();
    tick();
    tick();
    chk("held_no_compare_entry", 32'(entry_out), 32'hA);
    chk("held_still_locked", 32'(unlocked), 32'd0);
    btn_check = 1'b0;
    tick();

    // Reach lockout, reset at count 4 with check held
    attempt(4'h5);
    attempt(4'h5);
    attempt(4'h5);
    chk("lk2_alarm", 32'(alarm), 32'd1);
    tick();
    tick();
    tick();
    chk("lk2_alarm_mid", 32'(alarm), 32'd1);
    btn_check = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_unlocked", 32'(unlocked), 32'd1);
    chk("mid_rst_alarm", 32'(alarm), 32'd0);
    chk("mid_rst_key", 32'(key_out), 32'h0);
    chk("mid_rst_entry", 32'(entry_out), 32'h0);
    chk("mid_rst_tries", 32'(tries_left), 32'd3);
    tick();
    tick();
    chk("held_after_rst", 32'(unlocked), 32'd1);
    btn_check = 1'b0;
    tick();
    btn_check = 1'b1;
    tick();
    chk("press_after_release", 32'(unlocked), 32'd0);
    btn_check = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
